// File: rtl/blinker_pkg.sv
// -----------------------------------------------------------------------------
// blinker_pkg
//   Shared definitions for the multi-channel blinker:
//     - mode_t      : 2-bit channel mode (OFF / ON / BLINK / ONESHOT)
//     - MS_PER_S    : milliseconds per second, used to derive the prescaler
// -----------------------------------------------------------------------------
package blinker_pkg;

    // Channel operating mode, encoded exactly as written on cfg_mode.
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    localparam int unsigned MS_PER_S = 1000;

endpackage : blinker_pkg

// File: rtl/ms_tick.sv
// -----------------------------------------------------------------------------
// ms_tick
//   Millisecond prescaler shared by all blinker channels. Counts
//   0 .. C_CLK_FRQ/1000-1 and strobes tick on the terminal count, then wraps.
//
// Parameters
//   C_CLK_FRQ : clock frequency in Hz (multiple of 1000)
//
// Ports
//   clk  in  : master clock
//   rstb in  : asynchronous active-low reset
//   en   in  : count enable; when low the counter is held at 0, tick = 0
//   clr  in  : synchronous clear; forces the counter to 0, suppresses tick
//   tick out : one-cycle strobe, high during the terminal-count cycle
// -----------------------------------------------------------------------------
module ms_tick
    import blinker_pkg::*;
#(
    parameter int unsigned C_CLK_FRQ = 100_000_000
) (
    input  logic clk,
    input  logic rstb,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV   = C_CLK_FRQ / MS_PER_S;
    localparam int          CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours regardless of block order.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (!en || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Combinational decode of the terminal count; a clear in the same cycle
    // wins so no channel advances while being realigned.
    assign tick = en & ~clr & (cnt == LAST);

endmodule : ms_tick

// File: rtl/blinker_multi.sv
// -----------------------------------------------------------------------------
// blinker_multi
//   Multi-channel, runtime-programmable blinker. One shared millisecond
//   prescaler (ms_tick) drives C_CHANNELS independent channels, each with its
//   own mode, period and on-time written through a single-cycle config port.
//
//   Optional feature: define BLINKER_MULTI_SYNC_EN to add the sync input,
//   which clears the prescaler and all channel phases on the next edge.
//
// Parameters
//   C_CLK_FRQ    : clock frequency in Hz (multiple of 1000)
//   C_CHANNELS   : number of channels, 1..16
//   C_TIME_WIDTH : width of period / on-time / phase fields (ms)
//
// Ports
//   clk        in  : master clock
//   rstb       in  : asynchronous active-low reset
//   en         in  : global enable (low: prescaler/phases held, outputs 0)
//   cfg_wr     in  : one-cycle configuration write strobe
//   cfg_ch     in  : target channel (writes to nonexistent channels ignored)
//   cfg_mode   in  : 0 OFF, 1 ON, 2 BLINK, 3 ONESHOT
//   cfg_period in  : BLINK period in ms
//   cfg_on     in  : high time in ms
//   out        out : registered channel outputs
//   done       out : one-cycle pulse per BLINK wrap / ONESHOT completion
//   tick       out : one-cycle millisecond strobe
//   sync       in  : (BLINKER_MULTI_SYNC_EN only) realign all channels
// -----------------------------------------------------------------------------
module blinker_multi
    import blinker_pkg::*;
#(
    parameter  int unsigned C_CLK_FRQ    = 100_000_000,
    parameter  int unsigned C_CHANNELS   = 3,
    parameter  int unsigned C_TIME_WIDTH = 12,
    localparam int          C_CH_W       = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    en,
    input  logic                    cfg_wr,
    input  logic [C_CH_W-1:0]       cfg_ch,
    input  logic [1:0]              cfg_mode,
    input  logic [C_TIME_WIDTH-1:0] cfg_period,
    input  logic [C_TIME_WIDTH-1:0] cfg_on,
    output logic [C_CHANNELS-1:0]   out,
    output logic [C_CHANNELS-1:0]   done,
    output logic                    tick
`ifdef BLINKER_MULTI_SYNC_EN
    ,
    input  logic                    sync
`endif
);

    localparam int TW = C_TIME_WIDTH;

    // -------------------------------------------------------------------------
    // Channel realignment source
    // -------------------------------------------------------------------------
    logic clr;

`ifdef BLINKER_MULTI_SYNC_EN
    assign clr = sync;
`else
    assign clr = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Shared millisecond prescaler
    // -------------------------------------------------------------------------
    ms_tick #(
        .C_CLK_FRQ (C_CLK_FRQ)
    ) u_ms_tick (
        .clk  (clk),
        .rstb (rstb),
        .en   (en),
        .clr  (clr),
        .tick (tick)
    );

    // -------------------------------------------------------------------------
    // Channels
    //
    // Each channel is a two-stage pipeline:
    //   stage 1: mode/period/on/phase state, plus evt marking a wrap or
    //            ONESHOT completion that happened on this edge;
    //   stage 2: out/done registers, loaded from stage-1 state.
    // A write or tick at edge n is therefore visible on out/done at edge n+1,
    // and done lines up with the out update caused by the same wrap.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < int'(C_CHANNELS); i++) begin : g_ch

        mode_t         mode;
        logic [TW-1:0] period;
        logic [TW-1:0] on_time;
        logic [TW-1:0] phase;
        logic          evt;
        logic          out_q;
        logic          done_q;

        logic          wr_hit;
        logic          level;
        logic          blink_last;
        logic          osh_last;

        // Out-of-range channel numbers never match any i, so they are dropped.
        assign wr_hit = cfg_wr && (cfg_ch == C_CH_W'(i));

        // Wrap / completion decode. The period-1 term is only consulted when
        // period is non-zero, so its underflow is harmless.
        assign blink_last = (phase >= period - TW'(1));
        assign osh_last   = (on_time == '0) || (phase >= on_time - TW'(1));

        // NOTE: every variable assigned in always_comb gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        always_comb begin
            level = 1'b0;
            unique case (mode)
                MODE_ON:      level = 1'b1;
                MODE_BLINK:   level = (period != '0) && (phase < on_time);
                MODE_ONESHOT: level = (phase < on_time);
                default:      level = 1'b0;
            endcase
        end

        // NOTE: the per-channel configuration lives in plain flops, not a
        // RAM, so it is reset along with the rest of the state; this gives a
        // defined all-OFF power-up without relying on the controller.
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                mode    <= MODE_OFF;
                period  <= '0;
                on_time <= '0;
                phase   <= '0;
                evt     <= 1'b0;
                out_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                // Stage 2: outputs follow the state present before this edge.
                if (en) begin
                    out_q  <= level;
                    done_q <= evt;
                end else begin
                    out_q  <= 1'b0;
                    done_q <= 1'b0;
                end

                // Stage 1 default: no wrap/completion this edge.
                evt <= 1'b0;

                if (wr_hit) begin
                    // A write always restarts the channel, even on a tick.
                    mode    <= mode_t'(cfg_mode);
                    period  <= cfg_period;
                    on_time <= cfg_on;
                    phase   <= '0;
                end else if (!en || clr) begin
                    phase <= '0;
                end else if (tick) begin
                    unique case (mode)
                        MODE_BLINK: begin
                            if (period == '0) begin
                                phase <= '0;
                            end else if (blink_last) begin
                                phase <= '0;
                                evt   <= 1'b1;
                            end else begin
                                phase <= phase + TW'(1);
                            end
                        end
                        MODE_ONESHOT: begin
                            if (osh_last) begin
                                phase <= '0;
                                mode  <= MODE_OFF;
                                evt   <= 1'b1;
                            end else begin
                                phase <= phase + TW'(1);
                            end
                        end
                        default: begin
                            phase <= '0;
                        end
                    endcase
                end
            end
        end

        assign out[i]  = out_q;
        assign done[i] = done_q;

    end : g_ch

endmodule : blinker_multi

// File: tb/tb_blinker_multi.sv
// -----------------------------------------------------------------------------
// tb_blinker_multi
//   Self-checking bench for blinker_multi (10 clocks per ms, 3 channels).
//   A reference model tracks, per channel, the number of milliseconds since
//   the channel was (re)started and derives the expected pattern from it
//   with modulo arithmetic. Expected out/done are queued each clock and a
//   separate monitor pops and compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_blinker_multi;
    import blinker_pkg::*;

    localparam int unsigned CLK_FRQ = 10_000;
    localparam int unsigned NCH     = 3;
    localparam int unsigned TW      = 12;
    localparam int          DIV     = CLK_FRQ / 1000;

    typedef struct packed {
        logic [NCH-1:0] out;
        logic [NCH-1:0] done;
    } exp_t;

    logic           clk = 1'b0;
    logic           rstb;
    logic           en;
    logic           cfg_wr;
    logic [1:0]     cfg_ch;
    logic [1:0]     cfg_mode;
    logic [TW-1:0]  cfg_period;
    logic [TW-1:0]  cfg_on;
    logic [NCH-1:0] out;
    logic [NCH-1:0] done;
    logic           tick;
    logic           sync;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    blinker_multi #(
        .C_CLK_FRQ    (CLK_FRQ),
        .C_CHANNELS   (NCH),
        .C_TIME_WIDTH (TW)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .en         (en),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_on     (cfg_on),
        .out        (out),
        .done       (done),
        .tick       (tick)
`ifdef BLINKER_MULTI_SYNC_EN
        ,
        .sync       (sync)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: elapsed ms per channel since (re)start
    // ------------------------------------------------------------------------
    mode_t m_mode [NCH];
    int    m_per  [NCH];
    int    m_on   [NCH];
    int    m_t    [NCH];
    bit    m_pend [NCH];
    int    m_pc;
    exp_t  sb [$];

    function automatic bit m_level(int i);
        case (m_mode[i])
            MODE_ON:      return 1'b1;
            MODE_BLINK:   return (m_per[i] != 0) && ((m_t[i] % m_per[i]) < m_on[i]);
            MODE_ONESHOT: return m_t[i] < m_on[i];
            default:      return 1'b0;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_mode[i] = MODE_OFF;
            m_per[i]  = 0;
            m_on[i]   = 0;
            m_t[i]    = 0;
            m_pend[i] = 1'b0;
        end
        m_pc = 0;
    endtask

    task automatic m_step();
        exp_t e;
        bit   tk;
        int   need;
        for (int i = 0; i < NCH; i++) begin
            e.out[i]  = en && m_level(i);
            e.done[i] = en && m_pend[i];
        end
        sb.push_back(e);
        tk = en && !sync && (m_pc == DIV - 1);
        m_pc = (!en || sync) ? 0 : (m_pc + 1) % DIV;
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = 1'b0;
            if (cfg_wr && int'(cfg_ch) == i) begin
                m_mode[i] = mode_t'(cfg_mode);
                m_per[i]  = int'(cfg_period);
                m_on[i]   = int'(cfg_on);
                m_t[i]    = 0;
            end else if (!en || sync) begin
                m_t[i] = 0;
            end else if (tk) begin
                case (m_mode[i])
                    MODE_BLINK: begin
                        if (m_per[i] != 0) begin
                            m_t[i]++;
                            if (m_t[i] % m_per[i] == 0) m_pend[i] = 1'b1;
                        end
                    end
                    MODE_ONESHOT: begin
                        m_t[i]++;
                        need = (m_on[i] > 0) ? m_on[i] : 1;
                        if (m_t[i] >= need) begin
                            m_pend[i] = 1'b1;
                            m_mode[i] = MODE_OFF;
                            m_t[i]    = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rstb);
            if (!rstb) begin
                m_reset();
                sb.delete();
            end else begin
                m_step();
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: compares on the falling edge, away from the active edge
    // ------------------------------------------------------------------------
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            check("tick", tick, rstb && en && !sync && (m_pc == DIV - 1));
            if (rstb && sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("out", out, mon_e.out);
                check("done", done, mon_e.done);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after the rising edge)
    // ------------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input int ch, input int mode, input int per, input int on);
        cfg_ch     = 2'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = TW'(per);
        cfg_on     = TW'(on);
        cfg_wr     = 1'b1;
        cyc(1);
        cfg_wr     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int  nticks;
        bit  found;
        rstb       = 1'b0;
        en         = 1'b0;
        cfg_wr     = 1'b0;
        cfg_ch     = '0;
        cfg_mode   = '0;
        cfg_period = '0;
        cfg_on     = '0;
        sync       = 1'b0;

        #3;
        check("reset_out", out, 0);
        check("reset_done", done, 0);
        check("reset_tick", tick, 0);

        // Release reset with enable; no channel configured yet.
        @(posedge clk); #2;
        rstb = 1'b1;
        en   = 1'b1;
        nticks = 0;
        repeat (40) begin
            @(negedge clk);
            if (tick) nticks++;
        end
        check("tick_count_40cyc", nticks, 4);
        cyc(1);

        // ch0 BLINK period 4, on 1.
        wr(0, MODE_BLINK, 4, 1);
        cyc(120);

        // ch1 ONESHOT on 3.
        wr(1, MODE_ONESHOT, 0, 3);
        cyc(70);

        // ch2 edge cases, then an out-of-range write.
        wr(2, MODE_BLINK, 0, 3);
        cyc(30);
        wr(2, MODE_BLINK, 4, 5);
        cyc(50);
        wr(2, MODE_BLINK, 4, 0);
        cyc(50);
        wr(3, MODE_ON, 2, 1);
        cyc(20);

        // Rewrite ch0 during a tick cycle.
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(posedge clk); #2;
            if (tick) found = 1'b1;
        end
        check("tick_wait", found, 1);
        if (found) begin
            wr(0, MODE_BLINK, 3, 2);
        end
        cyc(45);

        // Asynchronous reset mid-pattern.
        wr(1, MODE_ON, 0, 0);
        cyc(3);
        rstb = 1'b0;
        #1;
        check("async_rst_out", out, 0);
        check("async_rst_done", done, 0);
        cyc(2);
        rstb = 1'b1;
        cyc(15);

`ifdef BLINKER_MULTI_SYNC_EN
        // Offset ch0/ch2 then realign with sync.
        wr(0, MODE_BLINK, 4, 2);
        cyc(15);
        wr(2, MODE_BLINK, 4, 2);
        cyc(17);
        sync = 1'b1;
        cyc(1);
        sync = 1'b0;
        cyc(60);
`endif

        // Randomized traffic.
        repeat (80) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 7)));
            end else if (r == 5) begin
                en = ~en;
`ifdef BLINKER_MULTI_SYNC_EN
            end else if (r == 6) begin
                sync = 1'b1;
                cyc(1);
                sync = 1'b0;
`endif
            end
            cyc(int'($urandom_range(1, 40)));
        end
        en = 1'b1;
        cyc(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_blinker_multi

// File: doc/blinker_multi.md
# blinker_multi

Multi-channel, runtime-programmable successor of the single fixed-period blinker. One shared millisecond prescaler drives `C_CHANNELS` independent channels. Each channel has its own mode, period and on-time, and all are written through a single-cycle configuration port. It sits between the traffic-light controller FSM, which writes the configuration, and the lamp/LED outputs.

## Interface
**Parameters**
- `C_CLK_FRQ`, 100_000_000: clock frequency in Hz; must be a multiple of 1000.
- `C_CHANNELS`, 3: number of output channels, 1..16.
- `C_TIME_WIDTH`, 12: width of the period and on-time fields, in ms.

**Ports** (clock and reset first)
- `clk`  in  1: master clock.
- `rstb`  in  1: reset, asynchronous, active low.
- `en`  in  1: global enable.
- `cfg_wr`  in  1: one-cycle configuration write strobe.
- `cfg_ch`  in  $clog2(C_CHANNELS) (min 1): target channel.
- `cfg_mode`  in  2: 0 OFF, 1 ON, 2 BLINK, 3 ONESHOT.
- `cfg_period`  in  C_TIME_WIDTH: period in ms.
- `cfg_on`  in  C_TIME_WIDTH: high time in ms.
- `out`  out  C_CHANNELS: channel outputs, registered.
- `done`  out  C_CHANNELS: one-cycle pulse at the end of each BLINK period and at ONESHOT completion.
- `tick`  out  1: one-cycle ms strobe.
- `sync`  in  1: only present with `BLINKER_MULTI_SYNC_EN`.

## Operation
- **Prescaler:** counts 0..C_CLK_FRQ/1000−1. `tick` = 1 on the terminal count, then the prescaler wraps to 0.
- **Per-channel registers:** mode, period, on-time, and a phase counter of `C_TIME_WIDTH` bits.
- **Configuration write:** `cfg_wr` loads all three fields into channel `cfg_ch` and clears that channel's phase.
  - Writes with `cfg_ch` ≥ C_CHANNELS are ignored.
  - A write mid-cycle restarts the channel; no glitch-extension of the old pattern.
- **OFF:** `out` = 0; phase held at 0.
- **ON:** `out` = 1; phase held at 0.
- **BLINK:** on each `tick`, phase increments. When phase = period−1 it wraps to 0 and `done` pulses. `out` = (phase < on).
  - on = 0 → constant 0.
  - on ≥ period → constant 1.
  - period = 0 → treated as OFF; no `done`.
- **ONESHOT:** `out` = 1 while phase < on.
  - On the tick where phase reaches on−1: `done` pulses, mode becomes OFF, `out` = 0 next cycle.
  - on = 0 → immediate `done` on the next tick, then OFF.
- **`en` = 0:** prescaler and all phases held at 0, `out` = 0, `done` = 0, `tick` = 0.
  - Configuration writes are still accepted.
  - On `en` rising, patterns start from phase 0.
- **Write and tick on the same cycle:** the write wins, and the phase is 0 after that edge.
- **Reset:** all modes OFF, periods/on-times 0, phases 0, prescaler 0. `out`, `done`, `tick` = 0.

## Timing
- Configuration latency: write sampled at edge n; `out` reflects the new mode at n+1.
- `out` changes exactly one cycle after the `tick` that moves the phase across the on boundary.
- BLINK output period = period × C_CLK_FRQ/1000 clock cycles exactly, with no drift.
- `done` is coincident with the `out` update for the wrap or completion.
- `rstb` assertion mid-pattern clears outputs asynchronously.
- After deassertion, the first `tick` occurs C_CLK_FRQ/1000 cycles later.

## Configuration
- `BLINKER_MULTI_SYNC_EN` defined: adds the `sync` input.
  - `sync` = 1 clears the prescaler and every channel phase on the next edge, aligning all channels; it takes priority over the tick.
  - A `cfg_wr` on the same cycle still loads its channel, with phase 0.
  - Modes are unchanged.
- Macro undefined: no `sync` port; channels align only through writes or `en`.

## Structure
- Shared package `blinker_pkg`: mode encodings `MODE_OFF`/`ON`/`BLINK`/`ONESHOT` and the 2-bit mode type.
- Sub-module `ms_tick`: the prescaler, parameter C_CLK_FRQ, ports `clk`, `rstb`, `en`, `clr`, `tick`.
- Channel logic: a generate loop in `blinker_multi`.

## Test plan
Bench parameters: C_CLK_FRQ = 10_000 (10 cycles/ms), C_CHANNELS = 3.
- Reset, then `en` = 1 with no writes → `out` = 000, `done` = 000, `tick` every 10 cycles.
- Write ch0 BLINK, period 4, on 1 → `out[0]` high 10 cycles, low 30; `done[0]` every 40 cycles.
- Write ch1 ONESHOT, on 3 → `out[1]` high ~30 cycles; single `done[1]`; mode reads back OFF; stays 0.
- Edge values on ch2 BLINK: period 0 → 0; on 5 with period 4 → constant 1; on 0 → constant 0. Write with `cfg_ch` = 3 → no channel changes.
- Rewrite ch0 mid-period, on a tick cycle → phase restarts at 0; `out[0]` new pattern starts at edge+1. `rstb` pulse mid-pattern → all outputs 0 immediately.
- With `BLINKER_MULTI_SYNC_EN`: ch0/ch2 BLINK with offset phases, pulse `sync` → both `out` rise on the next cycle and stay aligned.
